// File: rtl/cube_color_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cube_color_pkg
//  Description : Facelet colour codes and the vote-count type shared by the
//                HSV facelet classifier and its bus interface.
//  Revision    : 1.0  initial release
// ============================================================================
package cube_color_pkg;

    typedef enum logic [2:0] {
        COLOR_WHITE   = 3'd0,
        COLOR_YELLOW  = 3'd1,
        COLOR_RED     = 3'd2,
        COLOR_ORANGE  = 3'd3,
        COLOR_GREEN   = 3'd4,
        COLOR_BLUE    = 3'd5,
        COLOR_UNKNOWN = 3'd7
    } color_t;

    typedef logic [4:0] vote_t;

    // Code 6 has a counter slot but never receives votes.
    localparam int c_NUM_CODES = 8;

endpackage
`default_nettype wire

// File: rtl/hsv_facelet_classify_if.sv
`default_nettype none
// ============================================================================
//  Interface   : hsv_facelet_if
//  Description : Request, sample and result signals of hsv_facelet_classify.
//                result_votes exists only when HSV_FACELET_CONF_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
interface hsv_facelet_if;
    import cube_color_pkg::*;

    logic        start;
    logic        hsv_valid;
    logic [23:0] HSV24;
    logic        busy;
    logic        result_valid;
    color_t      result_color;
`ifdef HSV_FACELET_CONF_EN
    vote_t       result_votes;
`endif

    modport master (
        output start, hsv_valid, HSV24,
`ifdef HSV_FACELET_CONF_EN
        input  result_votes,
`endif
        input  busy, result_valid, result_color
    );

    modport slave (
        input  start, hsv_valid, HSV24,
`ifdef HSV_FACELET_CONF_EN
        output result_votes,
`endif
        output busy, result_valid, result_color
    );

endinterface
`default_nettype wire

// File: rtl/hsv_color_match.sv
`default_nettype none
// ============================================================================
//  Module      : hsv_color_match
//  Description : Combinational priority classifier of one HSV sample into a
//                facelet colour code (dark, then white, then hue bins).
//  Revision    : 1.0  initial release
// ============================================================================
module hsv_color_match
    import cube_color_pkg::*;
#(
    parameter int V_DARK_MAX   = 40,
    parameter int S_WHITE_MAX  = 50,
    parameter int H_RED_MAX    = 8,
    parameter int H_ORANGE_MAX = 22,
    parameter int H_YELLOW_MAX = 45,
    parameter int H_GREEN_MAX  = 160,
    parameter int H_BLUE_MAX   = 250
) (
    input  logic [23:0] hsv_i,
    output color_t      color_o
);

    logic [7:0] w_h;
    logic [7:0] w_s;
    logic [7:0] w_v;

    assign w_h = hsv_i[23:16];
    assign w_s = hsv_i[15:8];
    assign w_v = hsv_i[7:0];

    // Hue above the blue bin wraps back round to red.
    always_comb begin
        color_o = COLOR_RED;
        if (int'(w_v) < V_DARK_MAX) begin
            color_o = COLOR_UNKNOWN;
        end else if (int'(w_s) < S_WHITE_MAX) begin
            color_o = COLOR_WHITE;
        end else if (int'(w_h) < H_RED_MAX) begin
            color_o = COLOR_RED;
        end else if (int'(w_h) < H_ORANGE_MAX) begin
            color_o = COLOR_ORANGE;
        end else if (int'(w_h) < H_YELLOW_MAX) begin
            color_o = COLOR_YELLOW;
        end else if (int'(w_h) < H_GREEN_MAX) begin
            color_o = COLOR_GREEN;
        end else if (int'(w_h) < H_BLUE_MAX) begin
            color_o = COLOR_BLUE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hsv_facelet_classify.sv
`default_nettype none
// ============================================================================
//  Module      : hsv_facelet_classify
//  Description : Votes SAMPLES HSV samples into per-colour counters and reports
//                the majority colour. Define HSV_FACELET_CONF_EN to add the
//                winning vote count output (result_votes).
//  Revision    : 1.0  initial release
// ============================================================================
module hsv_facelet_classify
    import cube_color_pkg::*;
#(
    parameter int SAMPLES      = 16,
    parameter int V_DARK_MAX   = 40,
    parameter int S_WHITE_MAX  = 50,
    parameter int H_RED_MAX    = 8,
    parameter int H_ORANGE_MAX = 22,
    parameter int H_YELLOW_MAX = 45,
    parameter int H_GREEN_MAX  = 160,
    parameter int H_BLUE_MAX   = 250
) (
    input  logic         pclk,
    input  logic         rst,
    hsv_facelet_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_DECIDE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam vote_t c_LAST_SAMPLE = vote_t'(SAMPLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic       hsv_prev_q;
    vote_t      votes_q [c_NUM_CODES];
    vote_t      sample_cnt_q;
    logic [2:0] idx_q;
    vote_t      cand_cnt_q;
    color_t     cand_color_q;
    logic       cand_vld_q;
    vote_t      best_cnt_q;
    color_t     best_color_q;
    logic       commit_q;
    logic       result_valid_q;
    color_t     result_color_q;

    color_t     w_class;
    logic       w_open;
    logic       w_accept;
    logic       w_last;

    hsv_color_match #(
        .V_DARK_MAX   (V_DARK_MAX),
        .S_WHITE_MAX  (S_WHITE_MAX),
        .H_RED_MAX    (H_RED_MAX),
        .H_ORANGE_MAX (H_ORANGE_MAX),
        .H_YELLOW_MAX (H_YELLOW_MAX),
        .H_GREEN_MAX  (H_GREEN_MAX),
        .H_BLUE_MAX   (H_BLUE_MAX)
    ) u_match (
        .hsv_i   (bus.HSV24),
        .color_o (w_class)
    );

    assign w_open   = (state_q == S_IDLE) && bus.start;
    assign w_accept = (state_q == S_ACCUM) && bus.hsv_valid && !hsv_prev_q;
    assign w_last   = w_accept && (sample_cnt_q == c_LAST_SAMPLE);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (bus.start)      state_d = S_ACCUM;
            S_ACCUM:  if (w_last)         state_d = S_DECIDE;
            S_DECIDE: if (idx_q == 3'd7)  state_d = S_DONE;
            S_DONE:                       state_d = S_IDLE;
            default:                      state_d = S_IDLE;
        endcase
    end

    // The edge detector runs in every state so a level already high when a
    // window opens is never mistaken for a fresh sample.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hsv_prev_q <= 1'b0;
        end else begin
            hsv_prev_q <= bus.hsv_valid;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst || w_open) begin
            for (int i = 0; i < c_NUM_CODES; i++) begin
                votes_q[i] <= '0;
            end
            sample_cnt_q <= '0;
        end else if (w_accept) begin
            votes_q[w_class] <= votes_q[w_class] + 5'd1;
            sample_cnt_q     <= sample_cnt_q + 5'd1;
        end
    end

    // Scan is pipelined: read one counter per DECIDE cycle, compare it the
    // cycle after, then register the winner onto the outputs.
    always_ff @(posedge pclk) begin
        if (rst) begin
            idx_q        <= '0;
            cand_cnt_q   <= '0;
            cand_color_q <= COLOR_UNKNOWN;
            cand_vld_q   <= 1'b0;
            best_cnt_q   <= '0;
            best_color_q <= COLOR_UNKNOWN;
            commit_q     <= 1'b0;
        end else begin
            cand_vld_q <= (state_q == S_DECIDE);
            commit_q   <= (state_q == S_DONE);
            if (state_q == S_DECIDE) begin
                cand_cnt_q   <= votes_q[idx_q];
                cand_color_q <= color_t'(idx_q);
                idx_q        <= (idx_q == 3'd5) ? 3'd7 : idx_q + 3'd1;
            end else begin
                idx_q <= '0;
            end
            if (w_open) begin
                best_cnt_q   <= '0;
                best_color_q <= COLOR_UNKNOWN;
            end else if (cand_vld_q && (cand_cnt_q > best_cnt_q)) begin
                best_cnt_q   <= cand_cnt_q;
                best_color_q <= cand_color_q;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            result_valid_q <= 1'b0;
            result_color_q <= COLOR_UNKNOWN;
        end else begin
            result_valid_q <= commit_q;
            if (commit_q) begin
                result_color_q <= best_color_q;
            end
        end
    end

`ifdef HSV_FACELET_CONF_EN
    vote_t result_votes_q;

    always_ff @(posedge pclk) begin
        if (rst) begin
            result_votes_q <= '0;
        end else if (commit_q) begin
            result_votes_q <= best_cnt_q;
        end
    end

    assign bus.result_votes = result_votes_q;
`endif

    assign bus.busy         = (state_q != S_IDLE);
    assign bus.result_valid = result_valid_q;
    assign bus.result_color = result_color_q;

endmodule
`default_nettype wire

// File: tb/tb_hsv_facelet_classify.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hsv_facelet_classify
//  Description : Directed self-checking bench for hsv_facelet_classify.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hsv_facelet_classify;

    logic pclk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    hsv_facelet_if u_if ();

    hsv_facelet_classify #(.SAMPLES(16)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (u_if)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_start();
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
    endtask

    // Leaves the bench 1 ns after the edge that accepts the final sample.
    task automatic send_samples(input logic [23:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            u_if.HSV24     = v;
            u_if.hsv_valid = 1'b1;
            tick();
            u_if.hsv_valid = 1'b0;
            if (i != n - 1) tick();
        end
    endtask

    task automatic wait_result(output int lat);
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            if (lat == 99) begin
                tick();
                if (u_if.result_valid === 1'b1) lat = i;
            end
        end
    endtask

    task automatic test_reset();
        u_if.start = 1'b0; u_if.hsv_valid = 1'b0; u_if.HSV24 = 24'h0;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b expected 0", u_if.busy); end
        checks++; if (u_if.result_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", u_if.result_valid); end
        checks++; if (u_if.result_color !== 3'd7) begin failures++; $display("FAIL reset_color: got %0d expected 7", u_if.result_color); end
`ifdef HSV_FACELET_CONF_EN
        checks++; if (u_if.result_votes !== 5'd0) begin failures++; $display("FAIL reset_votes: got %0d expected 0", u_if.result_votes); end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_red();
        int lat;
        do_start();
        checks++; if (u_if.busy !== 1'b1) begin failures++; $display("FAIL red_busy: got %0b expected 1", u_if.busy); end
        send_samples(24'h00FFFF, 16);
        wait_result(lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL red_latency: got %0d expected 9", lat); end
        checks++; if (u_if.result_color !== 3'd2) begin failures++; $display("FAIL red_color: got %0d expected 2", u_if.result_color); end
`ifdef HSV_FACELET_CONF_EN
        checks++; if (u_if.result_votes !== 5'd16) begin failures++; $display("FAIL red_votes: got %0d expected 16", u_if.result_votes); end
`endif
        tick();
        checks++; if (u_if.result_valid !== 1'b0) begin failures++; $display("FAIL red_pulse_width: got %0b expected 0", u_if.result_valid); end
        checks++; if (u_if.result_color !== 3'd2) begin failures++; $display("FAIL red_color_hold: got %0d expected 2", u_if.result_color); end
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL red_idle: got %0b expected 0", u_if.busy); end
    endtask

    task automatic test_tie();
        int lat;
        do_start();
        send_samples(24'h2AC8C8, 8);
        tick();
        send_samples(24'h7880C8, 8);
        wait_result(lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL tie_latency: got %0d expected 9", lat); end
        checks++; if (u_if.result_color !== 3'd1) begin failures++; $display("FAIL tie_color: got %0d expected 1", u_if.result_color); end
`ifdef HSV_FACELET_CONF_EN
        checks++; if (u_if.result_votes !== 5'd8) begin failures++; $display("FAIL tie_votes: got %0d expected 8", u_if.result_votes); end
`endif
        tick();
    endtask

    task automatic test_held_level();
        int lat;
        logic seen;
        seen = 1'b0;
        do_start();
        u_if.HSV24 = 24'hF0C8C8;
        u_if.hsv_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (u_if.result_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (u_if.busy !== 1'b1) begin failures++; $display("FAIL held_busy: got %0b expected 1", u_if.busy); end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL held_no_result: got %0b expected 0", seen); end
        u_if.hsv_valid = 1'b0;
        tick();
        send_samples(24'h7880C8, 15);
        wait_result(lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL held_latency: got %0d expected 9", lat); end
        checks++; if (u_if.result_color !== 3'd4) begin failures++; $display("FAIL held_color: got %0d expected 4", u_if.result_color); end
`ifdef HSV_FACELET_CONF_EN
        checks++; if (u_if.result_votes !== 5'd15) begin failures++; $display("FAIL held_votes: got %0d expected 15", u_if.result_votes); end
`endif
        tick();
    endtask

    task automatic test_dark_white();
        int lat;
        do_start();
        send_samples(24'h00FF10, 16);
        wait_result(lat);
        checks++; if (u_if.result_color !== 3'd7) begin failures++; $display("FAIL dark_color: got %0d expected 7", u_if.result_color); end
`ifdef HSV_FACELET_CONF_EN
        checks++; if (u_if.result_votes !== 5'd16) begin failures++; $display("FAIL dark_votes: got %0d expected 16", u_if.result_votes); end
`endif
        tick();
        do_start();
        send_samples(24'h0020C8, 16);
        wait_result(lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL white_latency: got %0d expected 9", lat); end
        checks++; if (u_if.result_color !== 3'd0) begin failures++; $display("FAIL white_color: got %0d expected 0", u_if.result_color); end
        tick();
    endtask

    task automatic test_reset_mid_window();
        int lat;
        logic seen;
        seen = 1'b0;
        do_start();
        send_samples(24'hC8C8C8, 10);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (u_if.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %0b expected 0", u_if.busy); end
        checks++; if (u_if.result_color !== 3'd7) begin failures++; $display("FAIL midrst_color: got %0d expected 7", u_if.result_color); end
        for (int i = 0; i < 12; i++) begin
            if (u_if.result_valid === 1'b1) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL midrst_no_pulse: got %0b expected 0", seen); end
        do_start();
        send_samples(24'hC8C8C8, 16);
        wait_result(lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL blue_latency: got %0d expected 9", lat); end
        checks++; if (u_if.result_color !== 3'd5) begin failures++; $display("FAIL blue_color: got %0d expected 5", u_if.result_color); end
        tick();
    endtask

    task automatic test_start_collisions();
        int lat;
        logic seen;
        seen = 1'b0;
        do_start();
        send_samples(24'h00FFFF, 5);
        tick();
        do_start();
        checks++; if (u_if.busy !== 1'b1) begin failures++; $display("FAIL busy_start_busy: got %0b expected 1", u_if.busy); end
        send_samples(24'h7880C8, 11);
        wait_result(lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL busy_start_latency: got %0d expected 9", lat); end
        checks++; if (u_if.result_color !== 3'd4) begin failures++; $display("FAIL busy_start_color: got %0d expected 4", u_if.result_color); end
`ifdef HSV_FACELET_CONF_EN
        checks++; if (u_if.result_votes !== 5'd11) begin failures++; $display("FAIL busy_start_votes: got %0d expected 11", u_if.result_votes); end
`endif
        repeat (2) tick();
        u_if.HSV24 = 24'h0020C8;
        u_if.start = 1'b1;
        u_if.hsv_valid = 1'b1;
        tick();
        u_if.start = 1'b0;
        u_if.hsv_valid = 1'b0;
        tick();
        send_samples(24'h2AC8C8, 15);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (u_if.result_valid === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL same_cycle_no_early: got %0b expected 0", seen); end
        checks++; if (u_if.busy !== 1'b1) begin failures++; $display("FAIL same_cycle_busy: got %0b expected 1", u_if.busy); end
        send_samples(24'h2AC8C8, 1);
        wait_result(lat);
        checks++; if (lat != 9) begin failures++; $display("FAIL same_cycle_latency: got %0d expected 9", lat); end
        checks++; if (u_if.result_color !== 3'd1) begin failures++; $display("FAIL same_cycle_color: got %0d expected 1", u_if.result_color); end
`ifdef HSV_FACELET_CONF_EN
        checks++; if (u_if.result_votes !== 5'd16) begin failures++; $display("FAIL same_cycle_votes: got %0d expected 16", u_if.result_votes); end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_red();
        test_tie();
        test_held_level();
        test_dark_white();
        test_reset_mid_window();
        test_start_collisions();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
